// File: rtl/uart_rx_frame.sv
// UART receiver: 16x oversampled deserialiser producing NB_DATA-bit payloads with done/error pulses.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the payload and the stop bit.
module uart_rx_frame #(
   parameter int NB_DATA = 10,
   parameter int SB_TICK = 16,
   parameter int DIVISOR = 163,
   parameter int NB_DIV  = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_rx_done,
   output logic               o_frame_err,
   output logic               o_parity_err
);

   localparam int NB_N = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

   localparam logic [NB_DIV-1:0] DIV_LAST = NB_DIV'(DIVISOR - 1);
   localparam logic [NB_DIV-1:0] DIV_ONE  = NB_DIV'(1);
   localparam logic [3:0]        S_MID    = 4'd7;
   localparam logic [3:0]        S_LAST   = 4'd15;
   localparam logic [3:0]        S_STOP   = 4'(SB_TICK - 1);
   localparam logic [NB_N-1:0]   N_LAST   = NB_N'(NB_DATA - 1);
   localparam logic [NB_N-1:0]   N_ONE    = NB_N'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
`ifdef UART_RX_PARITY_EN
      , ST_PARITY
`endif
   } state_t;

   logic               r_rxMeta;
   logic               r_rxSync;
   logic               r_rxPrev;
   logic [NB_DIV-1:0]  r_divCnt;

   state_t             r_state;
   logic [3:0]         r_sCnt;
   logic [NB_N-1:0]    r_nCnt;
   logic [NB_DATA-1:0] r_sr;
   logic [NB_DATA-1:0] r_data;
   logic               r_rxDone;
   logic               r_frameErr;

   state_t             w_nextState;
   logic [3:0]         w_nextS;
   logic [NB_N-1:0]    w_nextN;
   logic [NB_DATA-1:0] w_nextSr;
   logic [NB_DATA-1:0] w_nextData;
   logic               w_nextDone;
   logic               w_nextFerr;
   logic               w_tick;
   logic               w_fallEdge;

`ifdef UART_RX_PARITY_EN
   logic               r_parityErr;
   logic               r_parBad;
   logic               w_nextPerr;
   logic               w_nextParBad;
`endif

   assign w_tick     = (r_divCnt == DIV_LAST);
   assign w_fallEdge = r_rxPrev & ~r_rxSync;

   // Synchroniser flops reset high so a reset while the line idles never looks like a start edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rxMeta <= 1'b1;
         r_rxSync <= 1'b1;
         r_rxPrev <= 1'b1;
         r_divCnt <= '0;
      end else begin
         r_rxMeta <= i_rx;
         r_rxSync <= r_rxMeta;
         r_rxPrev <= r_rxSync;
         r_divCnt <= w_tick ? '0 : (r_divCnt + DIV_ONE);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_sCnt     <= '0;
         r_nCnt     <= '0;
         r_sr       <= '0;
         r_data     <= '0;
         r_rxDone   <= 1'b0;
         r_frameErr <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_sCnt     <= w_nextS;
         r_nCnt     <= w_nextN;
         r_sr       <= w_nextSr;
         r_data     <= w_nextData;
         r_rxDone   <= w_nextDone;
         r_frameErr <= w_nextFerr;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_parityErr <= 1'b0;
         r_parBad    <= 1'b0;
      end else begin
         r_parityErr <= w_nextPerr;
         r_parBad    <= w_nextParBad;
      end
   end
`endif

   // Every sampling decision is taken on a tick; between ticks the FSM only holds.
   always_comb begin
      w_nextState = r_state;
      w_nextS     = r_sCnt;
      w_nextN     = r_nCnt;
      w_nextSr    = r_sr;
      w_nextData  = r_data;
      w_nextDone  = 1'b0;
      w_nextFerr  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_nextPerr   = 1'b0;
      w_nextParBad = r_parBad;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_fallEdge) begin
               w_nextState = ST_START;
               w_nextS     = '0;
            end
         end
         ST_START: begin
            if (w_tick) begin
               if (r_sCnt == S_MID) begin
                  if (!r_rxSync) begin
                     w_nextState = ST_DATA;
                     w_nextS     = '0;
                     w_nextN     = '0;
                  end else begin
                     w_nextState = ST_IDLE;
                  end
               end else begin
                  w_nextS = r_sCnt + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_sCnt == S_LAST) begin
                  w_nextSr = {r_rxSync, r_sr[NB_DATA-1:1]};
                  w_nextS  = '0;
                  if (r_nCnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     w_nextState = ST_PARITY;
`else
                     w_nextState = ST_STOP;
`endif
                  end else begin
                     w_nextN = r_nCnt + N_ONE;
                  end
               end else begin
                  w_nextS = r_sCnt + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (w_tick) begin
               if (r_sCnt == S_LAST) begin
                  w_nextParBad = ^{r_sr, r_rxSync};
                  w_nextS      = '0;
                  w_nextState  = ST_STOP;
               end else begin
                  w_nextS = r_sCnt + 4'd1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (w_tick) begin
               if (r_sCnt == S_STOP) begin
                  w_nextState = ST_IDLE;
                  w_nextS     = '0;
                  if (!r_rxSync) begin
                     w_nextFerr = 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (r_parBad) begin
                     w_nextPerr = 1'b1;
`endif
                  end else begin
                     w_nextDone = 1'b1;
                     w_nextData = r_sr;
                  end
               end else begin
                  w_nextS = r_sCnt + 4'd1;
               end
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   assign o_data      = r_data;
   assign o_rx_done   = r_rxDone;
   assign o_frame_err = r_frameErr;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = r_parityErr;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: a frame-level model predicts one outcome per sent frame.
// Honours UART_RX_PARITY_EN by sending a parity bit and running the parity vectors.
module tb_uart_rx_frame;

   localparam int NB_DATA = 10;
   localparam int BIT_CLK = 64;

   localparam logic [1:0] K_DONE = 2'd0;
   localparam logic [1:0] K_FERR = 2'd1;
   localparam logic [1:0] K_PERR = 2'd2;

   typedef struct {
      logic [1:0]         kind;
      logic [NB_DATA-1:0] data;
   } event_t;

   logic               i_clk = 1'b0;
   logic               i_reset = 1'b1;
   logic               i_rx = 1'b1;
   logic [NB_DATA-1:0] o_data;
   logic               o_rx_done;
   logic               o_frame_err;
   logic               o_parity_err;

   event_t             expQueue[$];
   event_t             expItem;
   logic [NB_DATA-1:0] modelData = '0;
   logic [2:0]         pulses;
   logic [2:0]         reqPulses;
   logic               checkEn = 1'b0;
   int                 assertCount = 0;
   int                 failCount = 0;
   int                 obsDone = 0;
   int                 obsFerr = 0;
   int                 obsPerr = 0;

   uart_rx_frame #(
      .NB_DATA(NB_DATA),
      .SB_TICK(16),
      .DIVISOR(4),
      .NB_DIV (8)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_rx_done   (o_rx_done),
      .o_frame_err (o_frame_err),
      .o_parity_err(o_parity_err)
   );

   always #5 i_clk = ~i_clk;

   // Outcome of a whole frame from its line content alone: stop low beats parity, parity beats data.
   function automatic event_t expectedEvent(input logic [NB_DATA-1:0] payload,
                                            input logic stopBit, input logic parityBit);
      event_t e;
      e.data = payload;
      e.kind = K_DONE;
      if (!stopBit) e.kind = K_FERR;
`ifdef UART_RX_PARITY_EN
      else if (parityBit != ^payload) e.kind = K_PERR;
`else
      if (parityBit === 1'bx) e.kind = K_FERR;
`endif
      return e;
   endfunction

   task automatic waitClocks(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int required);
      assertCount++;
      if (actual != required) begin
         failCount++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
      end
   endtask

   task automatic applyReset(input int cycles);
      i_reset = 1'b1;
      expQueue.delete();
      modelData = '0;
      waitClocks(cycles);
      i_reset = 1'b0;
   endtask

   task automatic applyStimulus(input logic [NB_DATA-1:0] payload,
                                input logic stopBit, input logic parityBit);
      expQueue.push_back(expectedEvent(payload, stopBit, parityBit));
      i_rx = 1'b0;
      waitClocks(BIT_CLK);
      for (int i = 0; i < NB_DATA; i++) begin
         i_rx = payload[i];
         waitClocks(BIT_CLK);
      end
`ifdef UART_RX_PARITY_EN
      i_rx = parityBit;
      waitClocks(BIT_CLK);
`endif
      i_rx = stopBit;
      waitClocks(BIT_CLK);
   endtask

   task automatic waitDrain(input string name);
      int k = 0;
      while (expQueue.size() != 0 && k < 400) begin
         waitClocks(1);
         k++;
      end
      checkOutput(name, expQueue.size(), 0);
   endtask

   // Per-cycle comparison: any pulse must match the oldest predicted outcome; o_data tracks the model.
   always @(negedge i_clk) begin
      if (checkEn && !i_reset) begin
         pulses = {o_parity_err, o_frame_err, o_rx_done};
         if (pulses != 3'b000) begin
            obsDone += int'(o_rx_done);
            obsFerr += int'(o_frame_err);
            obsPerr += int'(o_parity_err);
            assertCount++;
            if (expQueue.size() == 0) begin
               failCount++;
               $display("[TB] FAIL unexpectedPulse: pulses(perr,ferr,done)=%b required=000", pulses);
            end else begin
               expItem = expQueue.pop_front();
               reqPulses = (expItem.kind == K_DONE) ? 3'b001 :
                           (expItem.kind == K_FERR) ? 3'b010 : 3'b100;
               if (pulses != reqPulses) begin
                  failCount++;
                  $display("[TB] FAIL pulseKind: pulses(perr,ferr,done)=%b required=%b", pulses, reqPulses);
               end
               if (expItem.kind == K_DONE) modelData = expItem.data;
            end
         end
         assertCount++;
         if (o_data !== modelData) begin
            failCount++;
            $display("[TB] FAIL dataTrack: o_data=0x%0h required=0x%0h", o_data, modelData);
         end
      end
   end

   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      waitClocks(1);
      applyReset(4);
      checkEn = 1'b1;
      checkOutput("resetData", int'(o_data), 0);
      checkOutput("resetDone", int'(o_rx_done), 0);
      checkOutput("resetFerr", int'(o_frame_err), 0);
      checkOutput("resetPerr", int'(o_parity_err), 0);
      waitClocks(BIT_CLK);

      $display("[TB] basic frame 0x205");
      applyStimulus(10'h205, 1'b1, 1'b1);
      waitDrain("drainBasic");
      checkOutput("basicData", int'(o_data), 'h205);
      waitClocks(BIT_CLK);

      $display("[TB] start glitch then frame 0x0AA");
      i_rx = 1'b0;
      waitClocks(16);
      i_rx = 1'b1;
      waitClocks(BIT_CLK * 3);
      checkOutput("glitchNoPulse", obsDone, 1);
      applyStimulus(10'h0AA, 1'b1, 1'b0);
      waitDrain("drainGlitch");
      checkOutput("afterGlitchData", int'(o_data), 'h0AA);
      waitClocks(BIT_CLK);

      $display("[TB] frame error with break");
      applyStimulus(10'h155, 1'b0, 1'b1);
      waitClocks(BIT_CLK * 6);
      checkOutput("drainBreak", expQueue.size(), 0);
      checkOutput("breakData", int'(o_data), 'h0AA);
      checkOutput("breakFerrCount", obsFerr, 1);
      i_rx = 1'b1;
      waitClocks(BIT_CLK * 2);

      $display("[TB] back-to-back frames");
      applyStimulus(10'h0AA, 1'b1, 1'b0);
      applyStimulus(10'h1FF, 1'b1, 1'b1);
      applyStimulus(10'h203, 1'b1, 1'b1);
      waitDrain("drainB2B");
      checkOutput("b2bData", int'(o_data), 'h203);
      checkOutput("b2bDoneCount", obsDone, 5);
      waitClocks(BIT_CLK);

      $display("[TB] reset mid-frame");
      i_rx = 1'b0;
      waitClocks(BIT_CLK);
      i_rx = 1'b1;
      waitClocks(BIT_CLK);
      i_rx = 1'b0;
      waitClocks(BIT_CLK);
      i_rx = 1'b1;
      waitClocks(20);
      applyReset(1);
      checkOutput("midResetData", int'(o_data), 0);
      checkOutput("midResetDone", int'(o_rx_done), 0);
      waitClocks(BIT_CLK * 3);
      applyStimulus(10'h0C3, 1'b1, 1'b0);
      waitDrain("drainAfterReset");
      checkOutput("afterResetData", int'(o_data), 'h0C3);
      waitClocks(BIT_CLK);

`ifdef UART_RX_PARITY_EN
      $display("[TB] parity frames");
      applyStimulus(10'h003, 1'b1, 1'b0);
      waitDrain("drainParityOk");
      checkOutput("parityOkData", int'(o_data), 'h003);
      waitClocks(BIT_CLK);
      applyStimulus(10'h007, 1'b1, 1'b0);
      waitDrain("drainParityBad");
      checkOutput("parityBadData", int'(o_data), 'h003);
      checkOutput("parityErrCount", obsPerr, 1);
      checkOutput("totalDone", obsDone, 7);
`else
      checkOutput("parityErrCount", obsPerr, 0);
      checkOutput("totalDone", obsDone, 6);
`endif
      checkOutput("totalFerr", obsFerr, 1);
      waitClocks(BIT_CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
